// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle signed 32-bit restoring divider sequencer
//
// Ports:
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset
//   ctrl_DIV       : start request, sampled on the rising edge
//   data_operandA  : dividend (two's complement), captured on an accepted start
//   data_operandB  : divisor (two's complement), captured on an accepted start
//   data_result    : quotient, registered
//   data_remainder : remainder, registered
//   data_exception : divide-by-zero / overflow flag, registered
//   data_resultRDY : one-cycle pulse marking valid outputs
//   busy           : high while iterating or sign-correcting

module div_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state, next_state;
    logic        accept;
    logic        div_zero;

    logic [4:0]  iter_cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] abs_b;
    logic        sign_a;
    logic        sign_b;
    logic        ovf;

    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;
    logic [31:0] rem_shift;
    logic [32:0] sub_sum;
    logic        no_borrow;

    // Magnitudes wrap naturally: |0x80000000| stays 0x80000000, which fits unsigned.
    assign abs_a_in = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b_in = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    assign div_zero = (data_operandB == 32'd0);

    // Shared subtractor: R' - |B| as R' + ~|B| + 1; carry-out set means R' >= |B|.
    // R < |B| <= 2^31 keeps R' within 32 bits, so no extra remainder bit is needed.
    assign rem_shift = {rem[30:0], quo[31]};
    assign sub_sum   = {1'b0, rem_shift} + {1'b0, ~abs_b} + 33'd1;
    assign no_borrow = sub_sum[32];

    assign busy = (state == S_RUN) || (state == S_FIX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: accept = ctrl_DIV;
            S_RUN:  if (iter_cnt == 5'd31) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: begin
                next_state = S_IDLE;
                accept     = ctrl_DIV;
            end
            default: next_state = S_IDLE;
        endcase
        if (accept) begin
            next_state = div_zero ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iter_cnt       <= 5'd0;
            quo            <= 32'd0;
            rem            <= 32'd0;
            abs_b          <= 32'd0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= 32'd0;
            data_remainder <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                data_result    <= 32'd0;
                data_remainder <= data_operandA;
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
            end else begin
                sign_a         <= data_operandA[31];
                sign_b         <= data_operandB[31];
                ovf            <= (data_operandA == 32'h8000_0000) &&
                                  (data_operandB == 32'hFFFF_FFFF);
                abs_b          <= abs_b_in;
                quo            <= abs_a_in;
                rem            <= 32'd0;
                iter_cnt       <= 5'd0;
                data_exception <= 1'b0;
                data_resultRDY <= 1'b0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (no_borrow) begin
                        rem <= sub_sum[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_shift;
                        quo <= {quo[30:0], 1'b0};
                    end
                    iter_cnt <= iter_cnt + 5'd1;
                end
                S_FIX: begin
                    data_result    <= (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
                    data_remainder <= sign_a ? (~rem + 32'd1) : rem;
                    data_exception <= ovf;
                    data_resultRDY <= 1'b1;
                end
                S_DONE: data_resultRDY <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking scoreboard bench for div_sequencer

module tb_div_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    div_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
        int          st;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start and queues its expected outcome; operands are
    // scrambled right after the start edge to prove they are not re-sampled.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic e, input int lat);
        exp_t x;
        x.q = q; x.r = r; x.e = e; x.lat = lat;
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        x.st = cyc;
        scb.push_back(x);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_result(input string tag);
        exp_t x;
        if (scb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            x = scb.pop_front();
            while (!data_resultRDY && (cyc - x.st) < 40) tick();
            check({tag, "_latency"}, cyc - x.st, x.lat);
            check({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd1);
            check({tag, "_quotient"}, data_result, x.q);
            check({tag, "_remainder"}, data_remainder, x.r);
            check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, x.e});
            check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic pulse_end(input string tag);
        tick();
        check({tag, "_rdy_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        mq;
        logic [31:0]        mr;

        reset         = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        tick();
        tick();
        check("reset_result", data_result, 32'd0);
        check("reset_remainder", data_remainder, 32'd0);
        check("reset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // 100/7 with an ignored start at iteration 10, then 9/3 launched in DONE.
        start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        check("run_busy", {31'd0, busy}, 32'd1);
        repeat (9) tick();
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        tick();
        ctrl_DIV      = 1'b0;
        wait_result("div_100_7");
        start(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        check("b2b_rdy_low", {31'd0, data_resultRDY}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_result("div_9_3_b2b");
        pulse_end("div_9_3_b2b");

        start(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        wait_result("div_m7_2");
        pulse_end("div_m7_2");

        start(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        wait_result("div_7_m2");
        pulse_end("div_7_m2");

        start(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 0);
        check("div0_busy", {31'd0, busy}, 32'd0);
        wait_result("div_5_0");
        pulse_end("div_5_0");
        check("div0_busy_after", {31'd0, busy}, 32'd0);

        start(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33);
        wait_result("div_ovf");
        pulse_end("div_ovf");

        start(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        wait_result("div_min_1");
        pulse_end("div_min_1");

        for (int i = 0; i < 6; i++) begin
            sa = $signed($urandom);
            sb = $signed($urandom_range(1, 5000));
            if (i[0]) sb = -sb;
            if (i == 5) sb = $signed($urandom | 32'h0000_0001);
            mq = sa / sb;
            mr = sa % sb;
            start(sa, sb, mq, mr, 1'b0, 33);
            wait_result("div_rand");
            pulse_end("div_rand");
        end

        // Abort mid-run: outputs clear immediately and no ready pulse follows.
        start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        repeat (16) tick();
        reset = 1'b0;
        #1;
        check("abort_result", data_result, 32'd0);
        check("abort_remainder", data_remainder, 32'd0);
        check("abort_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        void'(scb.pop_back());
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_rdy", {30'd0, data_resultRDY, busy}, 32'd0);
        end
        start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        wait_result("div_after_reset");
        pulse_end("div_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
